// File: rtl/fifo_pkg.sv
// Shared helpers and types for the single-clock FIFO.
package fifo_pkg;

    // Pointer width: enough bits to index DEPTH entries, never less than one.
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Level width: enough bits to hold 0..DEPTH inclusive.
    function automatic int unsigned fifo_lvl_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Sticky error classification used when reporting FIFO status.
    typedef enum logic [1:0] {
        FIFO_OK  = 2'd0,
        FIFO_OVF = 2'd1,
        FIFO_UDF = 2'd2
    } fifo_err_e;

endpackage

// File: rtl/fifo_ram.sv
// Storage array for sync_fifo: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [fifo_ptr_w(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [fifo_ptr_w(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, exact level, almost flags and sticky errors.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through read timing.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          full,
    output logic                          almost_full,
    output logic                          overflow,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          almost_empty,
    output logic                          underflow,
    output logic [fifo_lvl_w(DEPTH)-1:0]  level
);

    localparam int unsigned PW = fifo_ptr_w(DEPTH);
    localparam int unsigned LW = fifo_lvl_w(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push_ok, pop_ok;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // Accept decisions and next-state pointers, level, flags.
    always_comb begin
        push_ok  = wr_en && !full_q;
        pop_ok   = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (wr_en & full_q);
        udf_d    = udf_q | (rd_en & empty_q);
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
        else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
        full_d   = (level_d == LW'(DEPTH));
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= LW'(AF_THRESH));
        aempty_d = (level_d <= LW'(AE_THRESH));
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= (AF_THRESH == 0);
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is always presented; rd_en acknowledges it.
    assign rd_data  = ram_rd_data;
    assign rd_valid = !empty_q;
`else
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    // Capture the head entry on an accepted pop, otherwise hold data.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;
        if (pop_ok) rd_data_d = ram_rd_data;
    end

    // Read output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign level        = level_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model. Honors SYNC_FIFO_FWFT_EN.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned AF    = 5;
    localparam int unsigned AE    = 1;
    localparam int unsigned LW    = fifo_lvl_w(DEPTH);

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en;
    logic [DW-1:0] wr_data, rd_data;
    logic          full, almost_full, overflow, rd_valid, empty, almost_empty, underflow;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .underflow    (underflow),
        .level        (level)
    );

    // Reference model state
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_udf, m_rv;
    logic [DW-1:0] m_rd;
    int unsigned   n_checks = 0;
    int unsigned   n_errs   = 0;
    int unsigned   cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic fifo_err_e model_err();
        if (m_ovf) return FIFO_OVF;
        if (m_udf) return FIFO_UDF;
        return FIFO_OK;
    endfunction

    task automatic compare();
        int unsigned sz;
        sz = mq.size();
        chk("level",        32'(level),        sz);
        chk("full",         32'(full),         32'(sz == DEPTH));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("almost_full",  32'(almost_full),  32'(sz >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("rd_valid",     32'(rd_valid),     32'(sz != 0));
        if (sz != 0) chk("rd_data_head", 32'(rd_data), 32'(mq[0]));
`else
        chk("rd_valid",     32'(rd_valid),     32'(m_rv));
        chk("rd_data",      32'(rd_data),      32'(m_rd));
`endif
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
        int unsigned sz;
        rst = r; wr_en = w; wr_data = d; rd_en = rd;
        @(posedge clk);
        #1;
        cyc++;
        sz = mq.size();
        if (r) begin
            mq.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0; m_rd = '0;
        end else begin
            m_ovf = m_ovf | (w && sz == DEPTH);
            m_udf = m_udf | (rd && sz == 0);
            m_rv  = rd && sz != 0;
            if (m_rv) m_rd = mq.pop_front();
            if (w && sz < DEPTH) mq.push_back(d);
        end
        compare();
    endtask

    task automatic push(input logic [DW-1:0] d); step(1'b0, 1'b1, d, 1'b0); endtask
    task automatic pop();                         step(1'b0, 1'b0, '0, 1'b1); endtask
    task automatic both(input logic [DW-1:0] d); step(1'b0, 1'b1, d, 1'b1); endtask
    task automatic do_rst(input bit w);           step(1'b1, w, 8'h5A, 1'b0); endtask

    initial begin
        int unsigned bias_w, bias_r;
        m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0; m_rd = '0;

        // Reset state
        do_rst(1'b0);
        do_rst(1'b0);

        // Fill to full, then overflow attempt
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
        push(8'hAA);
        // Drain in order, then underflow-free end state
        for (int i = 0; i < 6; i++) pop();
        $display("phase fill/drain: sticky=%s", model_err().name());

        // Alternating push/pop wraps pointers several times
        for (int i = 0; i < 20; i++) begin
            push(8'(8'h40 + i));
            pop();
        end

        // Simultaneous push+pop at level 3, at full, at empty
        do_rst(1'b0);
        for (int i = 0; i < 3; i++) push(8'(8'h60 + i));
        both(8'h63);
        for (int i = 0; i < 3; i++) push(8'(8'h64 + i));
        both(8'h67);
        for (int i = 0; i < 5; i++) pop();
        both(8'h68);
        pop();
        $display("phase simultaneous: sticky=%s", model_err().name());

        // Pop while empty, underflow stays sticky
        do_rst(1'b0);
        pop();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
        push(8'h71);
        pop();

        // Reset mid-stream with wr_en high, then resume
        do_rst(1'b0);
        for (int i = 0; i < 4; i++) push(8'(8'h80 + i));
        do_rst(1'b1);
        push(8'h90);
        push(8'h91);
        pop();
        pop();

        // Randomized traffic with shifting bias and occasional reset
        bias_w = 50; bias_r = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                bias_w = $urandom_range(15, 85);
                bias_r = $urandom_range(15, 85);
            end
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < bias_w,
                 8'($urandom),
                 $urandom_range(0, 99) < bias_r);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
